// File: rtl/y_div_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default operand width and the divide-by-zero quotient fill.
package y_div_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Divide by zero yields an all-ones quotient at any width.
    localparam logic DZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/y_div_step.sv
// One restoring division step: shift in the next dividend bit, try to
// subtract the divisor magnitude, keep or restore the partial remainder.
module y_div_step
    import y_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] mb,
    output logic [WIDTH-1:0] p_out,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Subtract-mode adder (ctrl = 1): shifted + ~mb + 1. The shifted value
    // never exceeds 2*mb-1, so WIDTH+1 bits hold the signed difference.
    always_comb begin
        shifted = {p_in, bit_in};
        diff    = shifted + ~{1'b0, mb} + {{WIDTH{1'b0}}, 1'b1};
        qbit    = ~diff[WIDTH];
        p_out   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/y_div.sv
// Iterative signed/unsigned divider for the execute stage: one quotient bit
// per clock, valid/ready handshake on both sides, RISC-V divide-by-zero rules.
module y_div
    import y_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mb;
    logic             qs;
    logic             rs;
    logic [WIDTH-1:0] p_next;
    logic             qbit;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return '0 - x;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // qr starts as the dividend magnitude; its MSB feeds each step while
    // quotient bits shift in at the bottom, so after WIDTH steps it is Q.
    y_div_step #(.WIDTH(WIDTH)) u_step (
        .p_in   (pr),
        .bit_in (qr[WIDTH-1]),
        .mb     (mb),
        .p_out  (p_next),
        .qbit   (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pr    <= '0;
            qr    <= '0;
            mb    <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (b == '0) begin
                            q     <= {WIDTH{DZ_QUOT_FILL}};
                            r     <= a;
                            dz    <= 1'b1;
                            state <= DONE;
                        end else begin
                            pr    <= '0;
                            qr    <= (sgn && a[WIDTH-1]) ? neg(a) : a;
                            mb    <= (sgn && b[WIDTH-1]) ? neg(b) : b;
                            qs    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rs    <= sgn & a[WIDTH-1];
                            cnt   <= CW'(WIDTH - 1);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    pr  <= p_next;
                    qr  <= {qr[WIDTH-2:0], qbit};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q     <= qs ? neg(qr) : qr;
                    r     <= rs ? neg(pr) : pr;
                    dz    <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_div.sv
// Directed bench for y_div: vector table for quotient/remainder/latency plus
// hand-written backpressure and mid-run reset sequences.
module tb_y_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          elat;
    } vec_t;

    vec_t vecs[10];

    y_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Presents one operation and returns the number of edges after accept
    // until out_valid is seen (capped at 100).
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                 output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a        = av;
        b        = bv;
        sgn      = sv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] hq;
        logic [31:0] hr;
        logic        seen_valid;

        vecs[0] = '{"u100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33};
        vecs[1] = '{"s-7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
        vecs[2] = '{"s7_-2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33};
        vecs[3] = '{"u5_0",      32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          1'b1, 0};
        vecs[4] = '{"s5_0",      32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1, 0};
        vecs[5] = '{"s_ovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33};
        vecs[6] = '{"u_bigdiv",  32'hFFFFFFFF,   32'h80000001,   1'b0, 32'd1,          32'h7FFFFFFE,   1'b0, 33};
        vecs[7] = '{"u_small",   32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0, 33};
        vecs[8] = '{"s-100_-7",  32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, 33};
        vecs[9] = '{"u1000_10",  32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,          1'b0, 33};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        sgn       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_q",         q,                  32'd0);
        checkOutput("rst_r",         r,                  32'd0);
        checkOutput("rst_dz",        {31'b0, dz},        32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
            checkOutput({vecs[i].name, "_lat"}, lat,                vecs[i].elat);
            checkOutput({vecs[i].name, "_q"},   q,                  vecs[i].eq);
            checkOutput({vecs[i].name, "_r"},   r,                  vecs[i].er);
            checkOutput({vecs[i].name, "_dz"},  {31'b0, dz},        {31'b0, vecs[i].edz});
            handoff();
            checkOutput({vecs[i].name, "_idle"}, {31'b0, in_ready}, 32'd1);
            checkOutput({vecs[i].name, "_hold"}, q,                 vecs[i].eq);
        end

        // Backpressure: result must hold and new operands must be refused.
        applyStimulus(32'd20, 32'd3, 1'b0, lat);
        checkOutput("bp_lat", lat, 33);
        hq = 32'd6;
        hr = 32'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            a        = 32'd50;
            b        = 32'd0;
            checkOutput("bp_q",         q,                  hq);
            checkOutput("bp_r",         r,                  hr);
            checkOutput("bp_dz",        {31'b0, dz},        32'd0);
            checkOutput("bp_in_ready",  {31'b0, in_ready},  32'd0);
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_release_idle",  {31'b0, in_ready},  32'd1);
        checkOutput("bp_release_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_release_q",     q,                  hq);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a        = 32'd100;
        b        = 32'd7;
        sgn      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_q",         q,                  32'd0);
        checkOutput("abort_r",         r,                  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("abort_no_valid", {31'b0, seen_valid}, 32'd0);
        checkOutput("abort_idle",     {31'b0, in_ready},   32'd1);

        applyStimulus(32'd9, 32'd3, 1'b0, lat);
        checkOutput("post_lat", lat, 33);
        checkOutput("post_q",   q,   32'd3);
        checkOutput("post_r",   r,   32'd0);
        handoff();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
